// File: rtl/sea_de_iter.sv
// sea_de_iter: iterative SEA-style Feistel decryptor, one round per clock.
// Ports: clk, rst (sync, active-high); in_valid/in_ready + ci_l/ci_r/key
//        capture a block; out_valid/out_ready + pt_l/pt_r return it; busy.
module sea_de_iter #(
  parameter int NR = 92
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [47:0] ci_l,
  input  logic [47:0] ci_r,
  input  logic [47:0] key,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [47:0] pt_l,
  output logic [47:0] pt_r,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE,
    KEXP,
    ROUND,
    DONE
  } state_t;

  localparam logic [7:0] CNT_LAST = 8'(NR - 1);

  function automatic logic [47:0] badd(
    input logic [47:0] a,
    input logic [47:0] b
  );
    logic [47:0] y;
    for (int i = 0; i < 6; i++) begin
      y[8*i +: 8] = a[8*i +: 8] + b[8*i +: 8];
    end
    return y;
  endfunction

  function automatic logic [2:0] sb3(input logic [2:0] v);
    logic [2:0] o;
    case (v)
      3'd0: o = 3'd0;
      3'd1: o = 3'd5;
      3'd2: o = 3'd6;
      3'd3: o = 3'd7;
      3'd4: o = 3'd4;
      3'd5: o = 3'd3;
      3'd6: o = 3'd1;
      3'd7: o = 3'd2;
    endcase
    return o;
  endfunction

  // S-box applied per bit column of each word triple
  function automatic logic [47:0] sbox(input logic [47:0] x);
    logic [47:0] y;
    logic [2:0]  t;
    for (int g = 0; g < 2; g++) begin
      for (int j = 0; j < 8; j++) begin
        t = sb3({x[24*g+16+j], x[24*g+8+j], x[24*g+j]});
        y[24*g+j]    = t[0];
        y[24*g+8+j]  = t[1];
        y[24*g+16+j] = t[2];
      end
    end
    return y;
  endfunction

  function automatic logic [47:0] rmix(input logic [47:0] x);
    logic [47:0] y;
    logic [7:0]  b0;
    logic [7:0]  b2;
    y = x;
    for (int g = 0; g < 2; g++) begin
      b0 = x[24*g +: 8];
      b2 = x[24*g+16 +: 8];
      y[24*g +: 8]    = {b0[0], b0[7:1]};
      y[24*g+16 +: 8] = {b2[6:0], b2[7]};
    end
    return y;
  endfunction

  function automatic logic [47:0] rot_l(input logic [47:0] x);
    return {x[39:0], x[47:40]};
  endfunction

  function automatic logic [47:0] rot_r(input logic [47:0] x);
    return {x[7:0], x[47:8]};
  endfunction

  function automatic logic [47:0] f_fn(
    input logic [47:0] x,
    input logic [47:0] k
  );
    return rmix(sbox(badd(x, k)));
  endfunction

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [47:0] key_q, key_d;
  logic [47:0] dl_q, dl_d;
  logic [47:0] dr_q, dr_d;
  logic [47:0] pt_l_q, pt_l_d;
  logic [47:0] pt_r_q, pt_r_d;
  logic        out_valid_q;
  logic        in_ready_q;
  logic        busy_q;
  logic [7:0]  cnt_inc;
  logic [47:0] dec_l;

  assign cnt_inc = cnt_q + 8'd1;
  // L_i recovered from (L_{i+1}, R_{i+1}) with the current round key
  assign dec_l   = rot_r(dr_q ^ f_fn(dl_q, key_q));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    key_d   = key_q;
    dl_d    = dl_q;
    dr_d    = dr_q;
    pt_l_d  = pt_l_q;
    pt_r_d  = pt_r_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          dl_d    = ci_l;
          dr_d    = ci_r;
          key_d   = key;
          cnt_d   = 8'd0;
          state_d = KEXP;
        end
      end
      KEXP: begin
        key_d = rot_l(key_q) ^ {40'b0, cnt_inc};
        cnt_d = cnt_inc;
        if (cnt_inc == CNT_LAST) begin
          state_d = ROUND;
        end
      end
      ROUND: begin
        dl_d  = dec_l;
        dr_d  = dl_q;
        // walk the schedule backwards to K_{cnt-1}
        key_d = rot_r(key_q ^ {40'b0, cnt_q});
        if (cnt_q == 8'd0) begin
          pt_l_d  = dec_l;
          pt_r_d  = dl_q;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= 8'd0;
      key_q       <= 48'd0;
      dl_q        <= 48'd0;
      dr_q        <= 48'd0;
      pt_l_q      <= 48'd0;
      pt_r_q      <= 48'd0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      key_q       <= key_d;
      dl_q        <= dl_d;
      dr_q        <= dr_d;
      pt_l_q      <= pt_l_d;
      pt_r_q      <= pt_r_d;
      out_valid_q <= (state_d == DONE);
      in_ready_q  <= (state_d == IDLE);
      busy_q      <= (state_d != IDLE);
    end
  end

  assign out_valid = out_valid_q;
  assign in_ready  = in_ready_q;
  assign busy      = busy_q;
  assign pt_l      = pt_l_q;
  assign pt_r      = pt_r_q;

endmodule

// File: tb/tb_sea_de_iter.sv
// tb_sea_de_iter: random + directed bench for sea_de_iter (NR=2 and NR=92)
// against a transaction-level cipher model.
module tb_sea_de_iter;

  logic        clk = 1'b0;
  logic        rst [2];
  logic        iv  [2];
  logic        ir  [2];
  logic [47:0] cl  [2];
  logic [47:0] cr  [2];
  logic [47:0] ky  [2];
  logic        ov  [2];
  logic        ordy[2];
  logic [47:0] pl  [2];
  logic [47:0] pr  [2];
  logic        bsy [2];

  int nvec = 0;
  int nerr = 0;
  int cyc  = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  sea_de_iter #(.NR(2)) u_dut0 (
    .clk(clk), .rst(rst[0]),
    .in_valid(iv[0]), .in_ready(ir[0]),
    .ci_l(cl[0]), .ci_r(cr[0]), .key(ky[0]),
    .out_valid(ov[0]), .out_ready(ordy[0]),
    .pt_l(pl[0]), .pt_r(pr[0]), .busy(bsy[0])
  );

  sea_de_iter #(.NR(92)) u_dut1 (
    .clk(clk), .rst(rst[1]),
    .in_valid(iv[1]), .in_ready(ir[1]),
    .ci_l(cl[1]), .ci_r(cr[1]), .key(ky[1]),
    .out_valid(ov[1]), .out_ready(ordy[1]),
    .pt_l(pl[1]), .pt_r(pr[1]), .busy(bsy[1])
  );

  function automatic int nr_of(input int d);
    return (d == 0) ? 2 : 92;
  endfunction

  function automatic logic [47:0] rnd48();
    return {16'($urandom), $urandom};
  endfunction

  function automatic logic [47:0] badd(
    input logic [47:0] a,
    input logic [47:0] b
  );
    logic [47:0] y;
    for (int i = 0; i < 6; i++) begin
      y[8*i +: 8] = 8'((int'(a[8*i +: 8]) + int'(b[8*i +: 8])) % 256);
    end
    return y;
  endfunction

  function automatic logic [47:0] sbw(input logic [47:0] x);
    int tb[8];
    int v;
    int o;
    logic [47:0] y;
    tb = '{0, 5, 6, 7, 4, 3, 1, 2};
    for (int h = 0; h < 2; h++) begin
      for (int j = 0; j < 8; j++) begin
        v = int'(x[24*h+j]) + 2 * int'(x[24*h+8+j])
          + 4 * int'(x[24*h+16+j]);
        o = tb[v];
        y[24*h+j]    = 1'(o % 2);
        y[24*h+8+j]  = 1'((o / 2) % 2);
        y[24*h+16+j] = 1'(o / 4);
      end
    end
    return y;
  endfunction

  function automatic logic [47:0] rmix(input logic [47:0] x);
    logic [47:0] y;
    logic [7:0]  b;
    for (int i = 0; i < 6; i++) begin
      b = x[8*i +: 8];
      if (i % 3 == 0)      y[8*i +: 8] = {b[0], b[7:1]};
      else if (i % 3 == 2) y[8*i +: 8] = {b[6:0], b[7]};
      else                 y[8*i +: 8] = b;
    end
    return y;
  endfunction

  function automatic logic [47:0] wrot(input logic [47:0] x);
    return {x[39:0], x[47:40]};
  endfunction

  function automatic logic [47:0] wrot_inv(input logic [47:0] x);
    return {x[7:0], x[47:8]};
  endfunction

  function automatic logic [47:0] ff(
    input logic [47:0] x,
    input logic [47:0] k
  );
    return rmix(sbw(badd(x, k)));
  endfunction

  function automatic logic [47:0] key_at(input logic [47:0] k0, input int n);
    logic [47:0] k;
    k = k0;
    for (int i = 1; i <= n; i++) k = wrot(k) ^ {40'b0, 8'(i)};
    return k;
  endfunction

  function automatic logic [95:0] encrypt(
    input logic [47:0] l0,
    input logic [47:0] r0,
    input logic [47:0] k0,
    input int          nr
  );
    logic [47:0] l, r, k, t;
    l = l0; r = r0; k = k0;
    for (int i = 0; i < nr; i++) begin
      t = wrot(l) ^ ff(r, k);
      l = r;
      r = t;
      k = wrot(k) ^ {40'b0, 8'(i + 1)};
    end
    return {l, r};
  endfunction

  function automatic logic [95:0] decrypt(
    input logic [47:0] cl0,
    input logic [47:0] cr0,
    input logic [47:0] k0,
    input int          nr
  );
    logic [47:0] ks[256];
    logic [47:0] l, r, t;
    ks[0] = k0;
    for (int i = 1; i < nr; i++) ks[i] = wrot(ks[i-1]) ^ {40'b0, 8'(i)};
    l = cl0; r = cr0;
    for (int i = nr - 1; i >= 0; i--) begin
      t = wrot_inv(r ^ ff(l, ks[i]));
      r = l;
      l = t;
    end
    return {l, r};
  endfunction

  task automatic chk(
    input string       nm,
    input logic [63:0] act,
    input logic [63:0] exp
  );
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h, want %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Transaction-level model: idle / working for 2*NR-1 edges / done.
  int          ms   [2] = '{0, 0};
  int          mleft[2] = '{0, 0};
  logic [47:0] mpl  [2] = '{48'd0, 48'd0};
  logic [47:0] mpr  [2] = '{48'd0, 48'd0};
  logic [47:0] epl  [2] = '{48'd0, 48'd0};
  logic [47:0] epr  [2] = '{48'd0, 48'd0};
  logic [95:0] mt;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int d = 0; d < 2; d++) begin
      if (rst[d]) begin
        ms[d]  <= 0;
        mpl[d] <= 48'd0;
        mpr[d] <= 48'd0;
      end else if (ms[d] == 0) begin
        if (iv[d]) begin
          mt = decrypt(cl[d], cr[d], ky[d], nr_of(d));
          epl[d]   <= mt[95:48];
          epr[d]   <= mt[47:0];
          mleft[d] <= 2 * nr_of(d) - 1;
          ms[d]    <= 1;
        end
      end else if (ms[d] == 1) begin
        mleft[d] <= mleft[d] - 1;
        if (mleft[d] == 1) begin
          ms[d]  <= 2;
          mpl[d] <= epl[d];
          mpr[d] <= epr[d];
        end
      end else if (ordy[d]) begin
        ms[d] <= 0;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int d = 0; d < 2; d++) begin
        chk($sformatf("cyc_ov%0d", d), 64'(ov[d]), 64'(ms[d] == 2));
        chk($sformatf("cyc_rdy%0d", d), 64'(ir[d]), 64'(ms[d] == 0));
        chk($sformatf("cyc_busy%0d", d), 64'(bsy[d]), 64'(ms[d] != 0));
        chk($sformatf("cyc_ptl%0d", d), 64'(pl[d]), 64'(mpl[d]));
        chk($sformatf("cyc_ptr%0d", d), 64'(pr[d]), 64'(mpr[d]));
      end
    end
  end

  task automatic send(
    input int          d,
    input logic [47:0] l,
    input logic [47:0] r,
    input logic [47:0] k
  );
    cl[d] = l; cr[d] = r; ky[d] = k; iv[d] = 1'b1;
    @(negedge clk);
    iv[d] = 1'b0;
    cl[d] = rnd48(); cr[d] = rnd48(); ky[d] = rnd48();
  endtask

  task automatic wait_ov(input int d, input int budget, output int n);
    n = 0;
    while (ov[d] !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (ov[d] !== 1'b1) begin
      nvec++;
      nerr++;
      $display("FAIL wait_ov%0d: no out_valid within %0d cycles", d, budget);
    end
  endtask

  task automatic b2b(input int d);
    logic [47:0] vl[4], vr[4], vk[4];
    logic [95:0] e;
    int seen, prev, t, nr;
    nr   = nr_of(d);
    vl   = '{48'h0, 48'hFFFF_FFFF_FFFF, 48'h0, 48'hFFFF_FFFF_FFFF};
    vr   = '{48'h0, 48'hFFFF_FFFF_FFFF, 48'h0, 48'hFFFF_FFFF_FFFF};
    vk   = '{48'h0, 48'hFFFF_FFFF_FFFF, 48'hFFFF_FFFF_FFFF, 48'h0};
    seen = 0; prev = -1; t = 0;
    ordy[d] = 1'b1;
    cl[d] = vl[0]; cr[d] = vr[0]; ky[d] = vk[0]; iv[d] = 1'b1;
    while (seen < 4 && t < 4 * (2 * nr + 1) + 10) begin
      @(negedge clk);
      t++;
      if (ov[d] === 1'b1) begin
        e = decrypt(vl[seen], vr[seen], vk[seen], nr);
        chk($sformatf("b2b_ptl%0d", d), 64'(pl[d]), 64'(e[95:48]));
        chk($sformatf("b2b_ptr%0d", d), 64'(pr[d]), 64'(e[47:0]));
        if (prev >= 0) chk($sformatf("b2b_gap%0d", d), 64'(cyc - prev), 64'(2 * nr + 1));
        prev = cyc;
        seen++;
        if (seen < 4) begin
          cl[d] = vl[seen]; cr[d] = vr[seen]; ky[d] = vk[seen];
        end else begin
          iv[d] = 1'b0;
        end
      end
    end
    iv[d] = 1'b0;
    if (seen < 4) begin
      nvec++;
      nerr++;
      $display("FAIL b2b_timeout%0d: saw %0d of 4 blocks", d, seen);
    end
    @(negedge clk);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [95:0] e, ct;
    logic [47:0] hl, hr, k;
    int n, cnt_ov;

    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1; iv[d] = 1'b1; ordy[d] = 1'b1;
      cl[d] = rnd48(); cr[d] = rnd48(); ky[d] = rnd48();
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b0; iv[d] = 1'b0;
    end
    chk_en = 1'b1;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("rst_ov", 64'(ov[d]), 64'd0);
      chk("rst_busy", 64'(bsy[d]), 64'd0);
      chk("rst_rdy", 64'(ir[d]), 64'd1);
      chk("rst_ptl", 64'(pl[d]), 64'd0);
      chk("rst_ptr", 64'(pr[d]), 64'd0);
    end

    chk("pin_badd", 64'(badd(48'h01FF, 48'h0101)), 64'h0200);
    chk("pin_rot", 64'(wrot(48'h1122_3344_5566)), 64'h2233_4455_6611);
    chk("pin_s1", 64'(sbw(48'h000000_000001)), 64'h000000_010001);
    chk("pin_s7", 64'(sbw(48'h000000_010101)), 64'h000000_000100);
    chk("pin_s3", 64'(sbw(48'h000000_000101)), 64'h000000_010101);
    chk("pin_shi", 64'(sbw(48'h000001_000000)), 64'h010001_000000);
    chk("pin_f", 64'(ff(48'h000100, 48'h0)), 64'h020100);
    chk("pin_f_nc", 64'(ff(48'h0000FF, 48'h000001)), 64'h0);
    chk("pin_k3", 64'(key_at(48'h0, 3)), 64'h010203);
    e = encrypt(48'hDEAD_BEEF_CAFE, 48'h0011_2233_44FF, 48'h0123_4567_89AB, 92);
    ct = decrypt(e[95:48], e[47:0], 48'h0123_4567_89AB, 92);
    chk("pin_rt_l", 64'(ct[95:48]), 64'hDEAD_BEEF_CAFE);
    chk("pin_rt_r", 64'(ct[47:0]), 64'h0011_2233_44FF);

    // NR=2 latency
    hl = rnd48(); hr = rnd48(); k = rnd48();
    e = decrypt(hl, hr, k, 2);
    send(0, hl, hr, k);
    wait_ov(0, 20, n);
    chk("lat_nr2", 64'(n), 64'd3);
    chk("nr2_ptl", 64'(pl[0]), 64'(e[95:48]));
    chk("nr2_ptr", 64'(pr[0]), 64'(e[47:0]));
    repeat (2) @(negedge clk);

    // NR=92 round trip
    ct = encrypt(48'hDEAD_BEEF_CAFE, 48'h0011_2233_44FF, 48'h0123_4567_89AB, 92);
    send(1, ct[95:48], ct[47:0], 48'h0123_4567_89AB);
    wait_ov(1, 400, n);
    chk("lat_nr92", 64'(n), 64'd183);
    chk("rt_ptl", 64'(pl[1]), 64'hDEAD_BEEF_CAFE);
    chk("rt_ptr", 64'(pr[1]), 64'h0011_2233_44FF);
    repeat (2) @(negedge clk);

    // backpressure with an ignored in_valid pulse
    ordy[0] = 1'b0;
    hl = rnd48(); hr = rnd48(); k = rnd48();
    e = decrypt(hl, hr, k, 2);
    send(0, hl, hr, k);
    wait_ov(0, 20, n);
    chk("bp_ptl0", 64'(pl[0]), 64'(e[95:48]));
    for (int i = 0; i < 10; i++) begin
      chk("bp_ov", 64'(ov[0]), 64'd1);
      chk("bp_rdy", 64'(ir[0]), 64'd0);
      chk("bp_ptl", 64'(pl[0]), 64'(e[95:48]));
      chk("bp_ptr", 64'(pr[0]), 64'(e[47:0]));
      if (i == 3) begin
        iv[0] = 1'b1; cl[0] = rnd48(); cr[0] = rnd48(); ky[0] = rnd48();
      end
      if (i == 4) iv[0] = 1'b0;
      @(negedge clk);
    end
    ordy[0] = 1'b1;
    @(negedge clk);
    chk("bp_ov_drop", 64'(ov[0]), 64'd0);
    chk("bp_hold_l", 64'(pl[0]), 64'(e[95:48]));
    repeat (4) @(negedge clk);
    chk("bp_ignored", 64'(bsy[0]), 64'd0);

    // reset while in ROUND with cnt=40
    send(1, rnd48(), rnd48(), rnd48());
    repeat (142) @(negedge clk);
    chk("ab_busy_pre", 64'(bsy[1]), 64'd1);
    rst[1] = 1'b1;
    @(negedge clk);
    rst[1] = 1'b0;
    chk("ab_rdy", 64'(ir[1]), 64'd1);
    chk("ab_busy", 64'(bsy[1]), 64'd0);
    chk("ab_ov", 64'(ov[1]), 64'd0);
    cnt_ov = 0;
    for (int i = 0; i < 200; i++) begin
      if (ov[1] === 1'b1) cnt_ov++;
      @(negedge clk);
    end
    chk("ab_no_ov", 64'(cnt_ov), 64'd0);
    hl = rnd48(); hr = rnd48(); k = rnd48();
    e = decrypt(hl, hr, k, 92);
    send(1, hl, hr, k);
    wait_ov(1, 400, n);
    chk("ab_lat", 64'(n), 64'd183);
    chk("ab_ptl", 64'(pl[1]), 64'(e[95:48]));
    chk("ab_ptr", 64'(pr[1]), 64'(e[47:0]));
    repeat (2) @(negedge clk);

    b2b(0);
    b2b(1);

    // random traffic on both instances
    for (int c = 0; c < 1500; c++) begin
      for (int d = 0; d < 2; d++) begin
        rst[d]  = ($urandom_range(0, 299) == 0);
        iv[d]   = ($urandom_range(0, 3) == 0);
        ordy[d] = 1'($urandom_range(0, 1));
        cl[d] = rnd48(); cr[d] = rnd48(); ky[d] = rnd48();
      end
      @(negedge clk);
    end

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/sea_de_iter.md
SEA_DE_ITER -- requirements
Module: sea_de_iter

Interface
REQ-001 Parameter NR, default 92: number of Feistel rounds; the legal range is 2..255.
REQ-002 clk  in  1  sole clock; all state updates on its rising edge.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 in_valid  in  1  ciphertext block and key are present on the inputs.
REQ-005 in_ready  out  1  the block can accept a block; high only in IDLE.
REQ-006 ci_l, ci_r  in  48 each  ciphertext halves (L_NR, R_NR).
REQ-007 key  in  48  master key K_0.
REQ-008 out_valid  out  1  pt_l/pt_r hold a completed plaintext.
REQ-009 out_ready  in  1  the downstream consumer accepts the plaintext.
REQ-010 pt_l, pt_r  out  48 each  plaintext halves (L_0, R_0), registered.
REQ-011 busy  out  1  high whenever the state is not IDLE.

Function
REQ-012 Word view: each 48-bit half is 6 bytes, with w0 = bits[7:0] and w5 = bits[47:40].
REQ-013 ⊞ is bytewise addition mod 256, with no carry between bytes.
REQ-014 S is a bitsliced 3-bit S-box over the word triples (w0,w1,w2) and (w3,w4,w5). At each bit j, the value {w2[j],w1[j],w0[j]} maps through the table 0,5,6,7,4,3,1,2.
REQ-015 r rotates words in place:
- w0 and w3 rotate right by 1 bit;
- w1 and w4 are unchanged;
- w2 and w5 rotate left by 1 bit.
REQ-016 R is a word rotation: output word k = input word k-1, and output w0 = input w5. R^-1 is its inverse.
REQ-017 The round function is F(x,k) = r(S(x ⊞ k)).
REQ-018 Forward cipher definition (for the golden model only): L_{i+1} = R_i, R_{i+1} = R(L_i) xor F(R_i, K_i).
REQ-019 Key schedule: K_{i+1} = R(K_i) xor C(i+1), where C(n) = 40'b0 concatenated with n[7:0] (byte n in w0). The inverse is K_i = R^-1(K_{i+1} xor C(i+1)).
REQ-020 The decrypt round is: R_i = L_{i+1}, L_i = R^-1(R_{i+1} xor F(L_{i+1}, K_i)).
REQ-021 State machine IDLE -> KEXP -> ROUND -> DONE -> IDLE.
REQ-022 IDLE: when in_valid&in_ready, the block captures ci_l/ci_r into the data registers, captures key into the key register, sets cnt=0, and enters KEXP.
REQ-023 KEXP: each cycle, key <= R(key) xor C(cnt+1) and cnt <= cnt+1. After the update that sets cnt=NR-1, the next state is ROUND. This state lasts exactly NR-1 cycles.
REQ-024 ROUND: each cycle, the block applies one decrypt round using K_cnt and sets key <= R^-1(key xor C(cnt)).
- If cnt>0, cnt decrements and the state stays in ROUND.
- If cnt==0, the block loads pt_l/pt_r with the result and enters DONE.
- This state lasts exactly NR cycles.
REQ-025 DONE: out_valid=1, and pt_l/pt_r are stable. When out_valid&out_ready, the block returns to IDLE and out_valid deasserts on the next cycle.
REQ-026 Latency: if the block is accepted at edge E, out_valid rises after edge E+2*NR-1. A new block is accepted no earlier than the cycle after the out handshake.
REQ-027 in_valid while not in IDLE is ignored, and its inputs are not sampled.
REQ-028 Input fields are sampled only at the accept edge; later input changes have no effect on the block in flight.
REQ-029 pt_l/pt_r keep their last value after the handshake, until the next DONE load.
REQ-030 out_ready held high continuously gives a 1-cycle DONE. Back-to-back blocks are therefore spaced 2*NR+1 cycles.
REQ-031 cnt is 8 bits wide and never wraps within legal NR.

Reset
REQ-032 When rst=1 at a clock edge, the block enters IDLE and clears cnt, key, the data registers, pt_l and pt_r to 0.
REQ-033 During and after reset: out_valid=0, busy=0, in_ready=1 on the first cycle after reset is released.
REQ-034 Reset in any state aborts the block in flight. No out_valid is produced for the aborted block.
REQ-035 Reset has priority over a simultaneous accept or out handshake.

Verification
REQ-036 The bench shall cover these scenarios:
- Reset: assert rst for 2 cycles with in_valid=1 -> out_valid=0, pt=0, busy=0, in_ready=1 after release.
- NR=2 latency: accept at edge E -> out_valid first high after edge E+3, and pt equals the golden-model decryption.
- NR=92 round trip: key=0x0123456789AB, plaintext (0xDEADBEEFCAFE, 0x0011223344FF) encrypted by the golden model -> pt_l=0xDEADBEEFCAFE, pt_r=0x0011223344FF after 183 cycles.
- Backpressure: out_ready=0 for 10 cycles in DONE -> out_valid and pt stable, in_ready=0, and a second in_valid pulse is ignored.
- Reset mid-ROUND at cnt=40 -> IDLE next cycle, no out_valid, and the next accepted block decrypts correctly.
- All-zero and all-ones key/ciphertext with out_ready tied high -> golden-model match, back-to-back spacing 2*NR+1.
